fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader_pkg.sv | 18 +
 rtl/fifo_burst_reader.sv | 136 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and width helpers for the FIFO burst reader.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int BURST_CNT_WIDTH = 16;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains a source FIFO in bursts: requests a grant, streams beats pass-through, then settles.
// Beat path is combinational (zero latency); stalls on fifo_rd_valid=0 or m_ready=0 without ending the burst.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int SIZE_WIDTH = $clog2(DEPTH + 1),
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 64,
  parameter int SETTLE     = 4,
  parameter int LEN_WIDTH  = $clog2(BURST_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [SIZE_WIDTH-1:0]      readable,
  input  logic                       fifo_rd_valid,
  input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
  output logic                       fifo_rd_ready,
  output logic                       burst_req,
  output logic [LEN_WIDTH-1:0]       burst_len,
  input  logic                       burst_gnt,
  output logic                       m_valid,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic [BURST_CNT_WIDTH-1:0] burst_cnt
);

  localparam int IDLE_W   = cnt_width(TIMEOUT - 1);
  localparam int HOLD_MAX_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int HOLD_W   = cnt_width(HOLD_MAX_I);
  localparam int FULL_I   = (BURST_LEN < DEPTH) ? BURST_LEN : DEPTH;

  localparam logic [IDLE_W-1:0]     IDLE_MAX = IDLE_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]     HOLD_MAX = HOLD_W'(HOLD_MAX_I);
  localparam logic [SIZE_WIDTH-1:0] FULL_LVL = SIZE_WIDTH'(FULL_I);
  localparam logic [LEN_WIDTH-1:0]  FULL_LEN = LEN_WIDTH'(FULL_I);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

  state_t                     state_q, state_d;
  logic [IDLE_W-1:0]          idle_cnt_q, idle_cnt_d;
  logic [HOLD_W-1:0]          hold_cnt_q, hold_cnt_d;
  logic [LEN_WIDTH-1:0]       beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0]       burst_len_q, burst_len_d;
  logic [BURST_CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;

  logic xfer;
  logic beat_fire;
  logic last_beat;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idle_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = '0;
    hold_cnt_d  = hold_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    burst_len_d = burst_len_q;
    burst_cnt_d = burst_cnt_q;

    xfer      = (state_q == ST_XFER);
    beat_fire = xfer && fifo_rd_valid && m_ready;
    last_beat = xfer && (beat_cnt_q == burst_len_q - LEN_ONE);

    case (state_q)
      ST_IDLE: begin
        if (readable >= FULL_LVL) begin
          state_d     = ST_REQ;
          burst_len_d = FULL_LEN;
        end else if (readable != '0) begin
          // Partial level only flushes after a full idle window; count saturates.
          if (idle_cnt_q == IDLE_MAX) begin
            state_d     = ST_REQ;
            burst_len_d = LEN_WIDTH'(readable);
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (burst_gnt) begin
          state_d    = ST_XFER;
          beat_cnt_d = '0;
        end
      end
      ST_XFER: begin
        if (beat_fire) begin
          if (last_beat) begin
            state_d     = ST_HOLD;
            hold_cnt_d  = '0;
            beat_cnt_d  = '0;
            burst_cnt_d = burst_cnt_q + 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Source level lags our pops, so readable is not trusted until settled.
        if (hold_cnt_q == HOLD_MAX) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign burst_req     = (state_q == ST_REQ);
  assign burst_len     = burst_len_q;
  assign fifo_rd_ready = xfer && m_ready;
  assign m_valid       = xfer && fifo_rd_valid;
  assign m_data        = fifo_rd_data;
  assign m_last        = last_beat;
  assign burst_cnt     = burst_cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a queue-backed source FIFO, hand-computed expectations.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int SW = 6;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [SW-1:0] readable;
  logic          fifo_rd_valid;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_ready;
  logic          burst_req;
  logic [LW-1:0] burst_len;
  logic          burst_gnt;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic [15:0]   burst_cnt;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .DEPTH(32), .BURST_LEN(8), .TIMEOUT(64), .SETTLE(4)
  ) dut (
    .clk(clk), .rstn(rstn), .readable(readable),
    .fifo_rd_valid(fifo_rd_valid), .fifo_rd_data(fifo_rd_data), .fifo_rd_ready(fifo_rd_ready),
    .burst_req(burst_req), .burst_len(burst_len), .burst_gnt(burst_gnt),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .burst_cnt(burst_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] src_q[$];
  logic [31:0] got_q[$];
  bit          last_q[$];
  bit          gap;
  bit          mr_toggle;
  int          bad_pop;
  int          bad_gap;
  int          n;
  int          n2;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_src();
    fifo_rd_valid = (src_q.size() > 0) && !gap;
    fifo_rd_data  = (src_q.size() > 0) ? src_q[0] : 32'hDEAD_BEEF;
  endtask

  // One clock: sample settled values, cross the edge, update the source, park at negedge.
  task automatic cyc();
    bit pop;
    drive_src();
    #1;
    pop = fifo_rd_ready && fifo_rd_valid;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      last_q.push_back(m_last);
    end
    if (fifo_rd_ready && !m_ready) bad_pop++;
    if (gap && m_valid) bad_gap++;
    @(posedge clk);
    #1;
    if (pop) void'(src_q.pop_front());
    if (mr_toggle) m_ready = !m_ready;
    drive_src();
    @(negedge clk);
  endtask

  task automatic wait_req(output int cnt);
    cnt = 0;
    while (!burst_req && cnt < 300) begin
      cyc();
      cnt++;
    end
  endtask

  task automatic grant();
    burst_gnt = 1'b1;
    cyc();
    burst_gnt = 1'b0;
  endtask

  task automatic collect(input int nb, input int gap_at);
    int  k = 0;
    int  gleft = 0;
    bit  gdone = 0;
    while (got_q.size() < nb && k < 300) begin
      if (!gdone && gap_at >= 0 && got_q.size() >= gap_at) begin
        gap   = 1'b1;
        gleft = 5;
        gdone = 1'b1;
      end
      cyc();
      k++;
      if (gleft > 0) begin
        gleft--;
        if (gleft == 0) gap = 1'b0;
      end
    end
    gap = 1'b0;
  endtask

  task automatic chk_burst(input string tag, input int nb, input int blen, input logic [31:0] base);
    chk({tag, "_beats"}, 32'(got_q.size()), 32'(nb));
    for (int i = 0; i < nb; i++) begin
      chk({tag, "_data"}, got_q[i], base + 32'(i));
      chk({tag, "_last"}, 32'(last_q[i]), 32'(((i + 1) % blen) == 0));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(burst_req), 32'd0);
    chk({tag, "_len"},   32'(burst_len), 32'd0);
    chk({tag, "_mvld"},  32'(m_valid), 32'd0);
    chk({tag, "_mlast"}, 32'(m_last), 32'd0);
    chk({tag, "_rdy"},   32'(fifo_rd_ready), 32'd0);
    chk({tag, "_bcnt"},  32'(burst_cnt), 32'd0);
  endtask

  task automatic clear_got();
    got_q.delete();
    last_q.delete();
  endtask

  initial begin
    rstn = 1'b0; readable = '0; burst_gnt = 1'b0; m_ready = 1'b1;
    gap = 1'b0; mr_toggle = 1'b0; bad_pop = 0; bad_gap = 0;
    fifo_rd_valid = 1'b0; fifo_rd_data = '0;
    @(negedge clk);
    repeat (3) cyc();
    chk_reset("rst");
    rstn = 1'b1;
    repeat (2) cyc();

    // Full burst, grant two cycles after request.
    for (int i = 1; i <= 8; i++) src_q.push_back(32'(i));
    readable = 6'd8;
    wait_req(n);
    chk("s1_req_lat", 32'(n), 32'd1);
    chk("s1_len", 32'(burst_len), 32'd8);
    cyc(); cyc();
    chk("s1_req_held", 32'(burst_req), 32'd1);
    chk("s1_len_frozen", 32'(burst_len), 32'd8);
    readable = '0;
    grant();
    collect(8, -1);
    chk("s1_bcnt", 32'(burst_cnt), 32'd1);
    chk("s1_hold_quiet", 32'(m_valid || fifo_rd_ready || burst_req), 32'd0);
    chk_burst("s1", 8, 8, 32'd1);
    clear_got();
    repeat (8) cyc();

    // Partial level flushed by the idle timeout.
    for (int i = 0; i < 3; i++) src_q.push_back(32'hA1 + 32'(i));
    readable = 6'd3;
    wait_req(n);
    chk("s2_req_lat", 32'(n), 32'd64);
    chk("s2_len", 32'(burst_len), 32'd3);
    readable = '0;
    grant();
    collect(3, -1);
    chk_burst("s2", 3, 3, 32'hA1);
    chk("s2_bcnt", 32'(burst_cnt), 32'd2);
    clear_got();
    repeat (8) cyc();

    // Toggling m_ready plus a 5-cycle source gap.
    for (int i = 0; i < 8; i++) src_q.push_back(32'h100 + 32'(i));
    readable = 6'd8;
    wait_req(n);
    chk("s3_req_lat", 32'(n), 32'd1);
    readable = '0;
    grant();
    bad_pop = 0; bad_gap = 0;
    mr_toggle = 1'b1;
    collect(8, 3);
    mr_toggle = 1'b0;
    m_ready = 1'b1;
    repeat (4) cyc();
    chk_burst("s3", 8, 8, 32'h100);
    chk("s3_bad_pop", 32'(bad_pop), 32'd0);
    chk("s3_bad_gap", 32'(bad_gap), 32'd0);
    chk("s3_bcnt", 32'(burst_cnt), 32'd3);
    clear_got();
    repeat (4) cyc();

    // Reset mid-burst, then a fresh burst.
    for (int i = 0; i < 8; i++) src_q.push_back(32'h200 + 32'(i));
    readable = 6'd8;
    wait_req(n);
    readable = '0;
    grant();
    collect(4, -1);
    chk("s4_pre_beats", 32'(got_q.size()), 32'd4);
    m_ready = 1'b0;
    rstn = 1'b0;
    cyc();
    chk_reset("s4_rst");
    rstn = 1'b1;
    m_ready = 1'b1;
    clear_got();
    repeat (3) cyc();
    chk("s4_no_resume", 32'(got_q.size()), 32'd0);
    chk("s4_no_req", 32'(burst_req), 32'd0);
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(32'h300 + 32'(i));
    readable = 6'd8;
    wait_req(n);
    chk("s4_req_lat", 32'(n), 32'd1);
    readable = '0;
    grant();
    collect(8, -1);
    chk_burst("s4", 8, 8, 32'h300);
    chk("s4_bcnt", 32'(burst_cnt), 32'd1);
    clear_got();
    repeat (8) cyc();

    // Stray grant in IDLE, level held high through HOLD, back-to-back bursts.
    for (int i = 0; i < 24; i++) src_q.push_back(32'h400 + 32'(i));
    burst_gnt = 1'b1;
    cyc();
    burst_gnt = 1'b0;
    chk("s5_idle_gnt_vld", 32'(m_valid), 32'd0);
    chk("s5_idle_gnt_rdy", 32'(fifo_rd_ready), 32'd0);
    cyc();
    chk("s5_idle_gnt_vld2", 32'(m_valid), 32'd0);
    readable = 6'd20;
    wait_req(n);
    chk("s5_req_lat", 32'(n), 32'd1);
    grant();
    collect(8, -1);
    chk("s5_bcnt1", 32'(burst_cnt), 32'd2);
    chk("s5_hold_req", 32'(burst_req), 32'd0);
    burst_gnt = 1'b1;
    cyc();
    burst_gnt = 1'b0;
    wait_req(n2);
    chk("s5_hold_len", 32'(n2 + 1), 32'd5);
    chk("s5_len2", 32'(burst_len), 32'd8);
    grant();
    collect(16, -1);
    readable = '0;
    chk_burst("s5", 16, 8, 32'h400);
    chk("s5_bcnt2", 32'(burst_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
